// File: rtl/node_inject_unit_pkg.sv
// rtl/node_inject_unit_pkg.sv - flit field layout, port indices and dimension-order route select
package node_inject_unit_pkg;

  // Header fields sit at fixed low positions; payload and valid bit follow, so only
  // ValidBitPos and the widths move with the payload width.
  localparam int opPos           = 0;
  localparam int OpWidth         = 8;
  localparam int CoordWidth      = 3;
  localparam int dstXPos         = 8;
  localparam int dstYPos         = 11;
  localparam int dstZPos         = 14;
  localparam int srcXPos         = 17;
  localparam int srcYPos         = 20;
  localparam int srcZPos         = 23;
  localparam int seqPos          = 26;
  localparam int SeqWidth        = 23;
  localparam int payloadPos      = 49;
  localparam int DefPayloadWidth = 32;
  localparam int DefLgNumprocs   = 3;
  localparam int ValidBitPos     = payloadPos + DefPayloadWidth;
  localparam int FlitWidth       = ValidBitPos + 1;
  localparam int FlitChildWidth  = FlitWidth + DefLgNumprocs;

  localparam logic [2:0] XPOS  = 3'd0;
  localparam logic [2:0] YPOS  = 3'd1;
  localparam logic [2:0] ZPOS  = 3'd2;
  localparam logic [2:0] XNEG  = 3'd3;
  localparam logic [2:0] YNEG  = 3'd4;
  localparam logic [2:0] ZNEG  = 3'd5;
  localparam logic [2:0] LOCAL = 3'd6;

  typedef enum logic {PRIO_RED = 1'b0, PRIO_HOST = 1'b1} arb_state_t;

  function automatic logic [2:0] route_sel(input logic [2:0] dx, input logic [2:0] dy,
                                           input logic [2:0] dz, input logic [2:0] cx,
                                           input logic [2:0] cy, input logic [2:0] cz);
    if (dx > cx)      return XPOS;
    else if (dx < cx) return XNEG;
    else if (dy > cy) return YPOS;
    else if (dy < cy) return YNEG;
    else if (dz > cz) return ZPOS;
    else if (dz < cz) return ZNEG;
    else              return LOCAL;
  endfunction

endpackage

// File: rtl/node_inject_unit_if.sv
// rtl/node_inject_unit_if.sv - source, stall and inject-port bundle of the inject unit
interface node_inject_unit_if #(
  parameter int PayloadWidth = 32,
  parameter int lg_numprocs  = 3
);
  import node_inject_unit_pkg::*;

  localparam int FW  = payloadPos + PayloadWidth + 1;
  localparam int FCW = FW + lg_numprocs;

  logic [FW-1:0]  red_in;
  logic           red_in_valid;
  logic           red_ready;
  logic [FCW-1:0] host_in;
  logic           host_in_valid;
  logic           host_ready;
  logic [5:0]     port_stall;
  logic [FCW-1:0] inject_xpos, inject_ypos, inject_zpos;
  logic [FCW-1:0] inject_xneg, inject_yneg, inject_zneg;
  logic [FCW-1:0] local_out;
  logic           local_out_valid;

  modport master (
    output red_in, red_in_valid, host_in, host_in_valid, port_stall,
    input  red_ready, host_ready, inject_xpos, inject_ypos, inject_zpos,
           inject_xneg, inject_yneg, inject_zneg, local_out, local_out_valid
  );

  modport slave (
    input  red_in, red_in_valid, host_in, host_in_valid, port_stall,
    output red_ready, host_ready, inject_xpos, inject_ypos, inject_zpos,
           inject_xneg, inject_yneg, inject_zneg, local_out, local_out_valid
  );
endinterface

// File: rtl/node_inject_unit_fifo.sv
// rtl/node_inject_unit_fifo.sv - inject_fifo: synchronous first-word-fall-through FIFO
module inject_fifo #(
  parameter int WIDTH = 85,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/node_inject_unit.sv
// rtl/node_inject_unit.sv - two-source round-robin inject steering; INJECT_STATS_EN adds per-port counters
module node_inject_unit
  import node_inject_unit_pkg::*;
#(
  parameter logic [2:0] cur_x        = 3'd0,
  parameter logic [2:0] cur_y        = 3'd0,
  parameter logic [2:0] cur_z        = 3'd0,
  parameter int         lg_numprocs  = 3,
  parameter int         PayloadWidth = 32,
  parameter int         DEPTH        = 16
) (
  input  logic               clk,
  input  logic               rst,
  node_inject_unit_if.slave  io,
  output logic [95:0]        stat_count
);
  localparam int VB  = payloadPos + PayloadWidth;
  localparam int FW  = VB + 1;
  localparam int FCW = FW + lg_numprocs;

  logic [FCW-1:0] red_wide, red_head, host_head, out_flit;
  logic           red_full, red_empty, host_full, host_empty;
  logic           red_pop, host_pop, red_ok, host_ok, out_valid;
  logic [2:0]     red_sel, host_sel, out_sel;
  logic [7:0]     stall8;
  arb_state_t     state, state_nxt;

  // Reduce results carry no children and always mark themselves valid.
  assign red_wide = {{lg_numprocs{1'b0}}, io.red_in | {1'b1, {VB{1'b0}}}};
  assign io.red_ready  = !red_full;
  assign io.host_ready = !host_full;

  inject_fifo #(.WIDTH(FCW), .DEPTH(DEPTH)) u_red_fifo (
    .clk(clk), .rst(rst), .wr_data(red_wide), .wr_en(io.red_in_valid), .full(red_full),
    .rd_en(red_pop), .rd_data(red_head), .empty(red_empty)
  );

  inject_fifo #(.WIDTH(FCW), .DEPTH(DEPTH)) u_host_fifo (
    .clk(clk), .rst(rst), .wr_data(io.host_in), .wr_en(io.host_in_valid), .full(host_full),
    .rd_en(host_pop), .rd_data(host_head), .empty(host_empty)
  );

  assign red_sel  = route_sel(red_head[dstXPos +: 3], red_head[dstYPos +: 3],
                              red_head[dstZPos +: 3], cur_x, cur_y, cur_z);
  assign host_sel = route_sel(host_head[dstXPos +: 3], host_head[dstYPos +: 3],
                              host_head[dstZPos +: 3], cur_x, cur_y, cur_z);
  // LOCAL (and the unused index 7) never stall.
  assign stall8   = {2'b00, io.port_stall};
  assign red_ok   = !red_empty && !stall8[red_sel];
  assign host_ok  = !host_empty && !stall8[host_sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= PRIO_RED;
    else      state <= state_nxt;
  end

  always_comb begin
    red_pop   = 1'b0;
    host_pop  = 1'b0;
    state_nxt = state;
    if (red_ok && host_ok) begin
      if (state == PRIO_HOST) host_pop = 1'b1;
      else                    red_pop  = 1'b1;
    end else if (red_ok) begin
      red_pop = 1'b1;
    end else if (host_ok) begin
      host_pop = 1'b1;
    end
    if (red_pop)  state_nxt = PRIO_HOST;
    if (host_pop) state_nxt = PRIO_RED;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sel   <= 3'd0;
      out_flit  <= '0;
    end else begin
      out_valid <= red_pop || host_pop;
      out_sel   <= red_pop ? red_sel : host_sel;
      out_flit  <= red_pop ? red_head : host_head;
    end
  end

  assign io.inject_xpos     = (out_valid && out_sel == XPOS) ? out_flit : '0;
  assign io.inject_ypos     = (out_valid && out_sel == YPOS) ? out_flit : '0;
  assign io.inject_zpos     = (out_valid && out_sel == ZPOS) ? out_flit : '0;
  assign io.inject_xneg     = (out_valid && out_sel == XNEG) ? out_flit : '0;
  assign io.inject_yneg     = (out_valid && out_sel == YNEG) ? out_flit : '0;
  assign io.inject_zneg     = (out_valid && out_sel == ZNEG) ? out_flit : '0;
  assign io.local_out       = (out_valid && out_sel == LOCAL) ? out_flit : '0;
  assign io.local_out_valid = out_valid && (out_sel == LOCAL);

`ifdef INJECT_STATS_EN
  logic [15:0] cnt [6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 6; p++) cnt[p] <= 16'd0;
    end else begin
      for (int p = 0; p < 6; p++)
        if (out_valid && out_sel == 3'(p) && cnt[p] != 16'hFFFF) cnt[p] <= cnt[p] + 16'd1;
    end
  end

  assign stat_count = {cnt[5], cnt[4], cnt[3], cnt[2], cnt[1], cnt[0]};
`else
  assign stat_count = '0;
`endif
endmodule

// File: tb/tb_node_inject_unit.sv
// tb/tb_node_inject_unit.sv - scoreboard bench for node_inject_unit at node (1,1,1)
module tb_node_inject_unit;
  import node_inject_unit_pkg::*;

  localparam int PW  = 32;
  localparam int LG  = 3;
  localparam int VB  = payloadPos + PW;
  localparam int FW  = VB + 1;
  localparam int FCW = FW + LG;

  typedef struct {
    int             port;
    logic [FCW-1:0] flit;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [95:0] stat_count;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  node_inject_unit_if #(.PayloadWidth(PW), .lg_numprocs(LG)) bus ();

  node_inject_unit #(
    .cur_x(3'd1), .cur_y(3'd1), .cur_z(3'd1),
    .lg_numprocs(LG), .PayloadWidth(PW), .DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .io(bus.slave), .stat_count(stat_count)
  );

  logic [FCW-1:0] inj [6];
  assign inj[0] = bus.inject_xpos;
  assign inj[1] = bus.inject_ypos;
  assign inj[2] = bus.inject_zpos;
  assign inj[3] = bus.inject_xneg;
  assign inj[4] = bus.inject_yneg;
  assign inj[5] = bus.inject_zneg;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [2:0] dx, input logic [2:0] dy,
                                       input logic [2:0] dz, input logic [31:0] pl,
                                       input logic vld);
    logic [FW-1:0] f;
    f = '0;
    f[opPos +: 8]      = 8'h5A;
    f[dstXPos +: 3]    = dx;
    f[dstYPos +: 3]    = dy;
    f[dstZPos +: 3]    = dz;
    f[srcXPos +: 3]    = 3'd1;
    f[srcYPos +: 3]    = 3'd1;
    f[srcZPos +: 3]    = 3'd1;
    f[payloadPos +: 32] = pl;
    f[VB]              = vld;
    return f;
  endfunction

  function automatic logic [FCW-1:0] red_exp(input logic [FW-1:0] f);
    logic [FCW-1:0] e;
    e = {3'b000, f};
    e[VB] = 1'b1;
    return e;
  endfunction

  function automatic logic [FCW-1:0] hmk(input logic [2:0] dx, input logic [2:0] dy,
                                         input logic [2:0] dz, input logic [31:0] pl);
    return {3'b101, mk(dx, dy, dz, pl, 1'b1)};
  endfunction

  function automatic void push(input int p, input logic [FCW-1:0] f);
    exp_t e;
    e.port = p;
    e.flit = f;
    sb.push_back(e);
  endfunction

  task automatic step(input logic rv, input logic [FW-1:0] rf, input logic hv, input logic [FCW-1:0] hf);
    @(negedge clk);
    bus.red_in_valid  = rv;
    bus.red_in        = rf;
    bus.host_in_valid = hv;
    bus.host_in       = hf;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, '0);
  endtask

  // Monitor: every presented output must be the next expected flit on the expected port.
  int             mon_n;
  int             mon_port;
  logic [FCW-1:0] mon_val;
  exp_t           mon_e;

  always @(negedge clk) begin
    mon_n = 0;
    mon_port = -1;
    mon_val = '0;
    for (int p = 0; p < 6; p++) begin
      if (inj[p] != '0) begin
        mon_n++;
        mon_port = p;
        mon_val = inj[p];
      end
    end
    if (bus.local_out_valid || bus.local_out != '0) begin
      mon_n++;
      mon_port = 6;
      mon_val = bus.local_out;
    end
    if (mon_n > 1) begin
      check("single_output", 128'(mon_n), 128'(1));
    end else if (mon_n == 1) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 128'(mon_port), 128'(-1));
      end else begin
        mon_e = sb.pop_front();
        check("out_port", 128'(mon_port), 128'(mon_e.port));
        check("out_flit", 128'(mon_val), 128'(mon_e.flit));
      end
    end
  end

  logic [FW-1:0]  f1;
  logic [FW-1:0]  f5 [5];
  logic [FCW-1:0] h;

  initial begin
    bus.red_in = '0;
    bus.red_in_valid = 1'b0;
    bus.host_in = '0;
    bus.host_in_valid = 1'b0;
    bus.port_stall = 6'b0;
    repeat (2) @(negedge clk);
    check("rst_red_ready", 128'(bus.red_ready), 128'(1));
    check("rst_host_ready", 128'(bus.host_ready), 128'(1));
    check("rst_inject_or", 128'(inj[0] | inj[1] | inj[2] | inj[3] | inj[4] | inj[5]), 128'(0));
    check("rst_local_valid", 128'(bus.local_out_valid), 128'(0));
    check("rst_stat", 128'(stat_count), 128'(0));
    rst = 1'b1;
    idle(2);

    // Single reduce flit: xpos, two cycles after it is presented.
    f1 = mk(3'd3, 3'd1, 3'd1, 32'hDEADBEEF, 1'b0);
    push(0, red_exp(f1));
    step(1'b1, f1, 1'b0, '0);
    idle(1);
    check("latency_not_early", 128'(bus.inject_xpos), 128'(0));
    idle(1);
    check("latency_xpos", 128'(bus.inject_xpos), 128'(red_exp(f1)));
    idle(3);

    // Host flits: yneg, then local.
    h = hmk(3'd1, 3'd0, 3'd1, 32'h0000_0201);
    push(4, h);
    step(1'b0, '0, 1'b1, h);
    h = hmk(3'd1, 3'd1, 3'd1, 32'h0000_0202);
    push(6, h);
    step(1'b0, '0, 1'b1, h);
    idle(6);

    // Both sources every cycle: strict alternation starting with reduce.
    for (int i = 0; i < 8; i++) begin
      f1 = mk(3'd3, 3'd1, 3'd1, 32'h300 + i, 1'b0);
      h  = hmk(3'd1, 3'd3, 3'd1, 32'h400 + i);
      push(0, red_exp(f1));
      push(1, h);
      step(1'b1, f1, 1'b1, h);
    end
    idle(24);

    // Host fills behind a stalled xneg; reduce to ypos keeps flowing.
    bus.port_stall = 6'b001000;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1, hmk(3'd0, 3'd1, 3'd1, 32'h600 + i));
      if (i == 15) check("host_ready_before_full", 128'(bus.host_ready), 128'(1));
    end
    idle(1);
    check("host_ready_full", 128'(bus.host_ready), 128'(0));
    step(1'b0, '0, 1'b1, hmk(3'd0, 3'd1, 3'd1, 32'h6FF));
    for (int i = 0; i < 4; i++) begin
      f1 = mk(3'd1, 3'd3, 3'd1, 32'h700 + i, 1'b0);
      push(1, red_exp(f1));
      step(1'b1, f1, 1'b0, '0);
    end
    idle(6);
    check("host_ready_still_full", 128'(bus.host_ready), 128'(0));
    for (int i = 0; i < 16; i++) push(3, hmk(3'd0, 3'd1, 3'd1, 32'h600 + i));
    @(negedge clk);
    bus.port_stall = 6'b0;
    idle(24);

    // Reset with five flits buffered while one is on the output.
    bus.port_stall = 6'b000001;
    for (int i = 0; i < 5; i++) begin
      f5[i] = mk(3'd3, 3'd1, 3'd1, 32'h500 + i, 1'b0);
      step(1'b1, f5[i], 1'b0, '0);
    end
    idle(2);
    @(negedge clk);
    bus.port_stall = 6'b0;
    @(posedge clk);
    #1;
    check("pre_reset_xpos", 128'(bus.inject_xpos), 128'(red_exp(f5[0])));
    rst = 1'b0;
    #1;
    check("reset_xpos_cleared", 128'(bus.inject_xpos), 128'(0));
    check("reset_inject_or", 128'(inj[0] | inj[1] | inj[2] | inj[3] | inj[4] | inj[5]), 128'(0));
    check("reset_red_ready", 128'(bus.red_ready), 128'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(6);
    h = hmk(3'd1, 3'd1, 3'd1, 32'h0000_0801);
    push(6, h);
    step(1'b0, '0, 1'b1, h);
    idle(5);

    // Stats: three xpos and two zneg flits.
    for (int i = 0; i < 3; i++) begin
      f1 = mk(3'd2, 3'd1, 3'd1, 32'h900 + i, 1'b0);
      push(0, red_exp(f1));
      step(1'b1, f1, 1'b0, '0);
    end
    for (int i = 0; i < 2; i++) begin
      h = hmk(3'd1, 3'd1, 3'd0, 32'hA00 + i);
      push(5, h);
      step(1'b0, '0, 1'b1, h);
    end
    idle(6);
`ifdef INJECT_STATS_EN
    check("stat_count", 128'(stat_count), 128'({16'd2, 64'd0, 16'd3}));
`else
    check("stat_count", 128'(stat_count), 128'(0));
`endif

    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
